syn_counter_ctrl: RTL and testbench

Run controller for the team's synchronous binary counter. It accepts a start command with start value, end value and direction, then steps a BITS-wide counter once per clock until the end value is reached. It supports pause, abort and optional auto-reload, and reports `busy` and a one-cycle `done`. It sits between control logic, such as a timer scheduler or test sequencer, and the counter datapath.

---
 rtl/counter_pkg.sv | 19 +
 rtl/syn_up_down_counter_bv.sv | 45 ++++
 rtl/syn_counter_ctrl.sv | 124 ++++++++++++
 tb/tb_syn_counter_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// counter_pkg : shared types and constants for the counter run controller
// Revision    : 1.0
// ============================================================================
package counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/syn_up_down_counter_bv.sv
`default_nettype none
// ============================================================================
// syn_up_down_counter_bv : BITS-wide loadable up/down counter, load beats enable
// Revision               : 1.0
// ============================================================================
module syn_up_down_counter_bv
    import counter_pkg::*;
#(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            en,
    input  logic            dir,
    output logic [BITS-1:0] Q
);

    localparam logic [BITS-1:0] C_ONE = {{(BITS-1){1'b0}}, 1'b1};

    logic [BITS-1:0] cnt_q;
    logic [BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (dir == DIR_UP) ? (cnt_q + C_ONE) : (cnt_q - C_ONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule : syn_up_down_counter_bv
`default_nettype wire

// File: rtl/syn_counter_ctrl.sv
`default_nettype none
// ============================================================================
// syn_counter_ctrl : run controller (start/pause/abort/auto-reload) for a counter
// Revision         : 1.0
// ============================================================================
module syn_counter_ctrl
    import counter_pkg::*;
#(
    parameter int BITS        = 5,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            dir,
    input  logic [BITS-1:0] start_val,
    input  logic [BITS-1:0] end_val,
    input  logic            pause,
    input  logic            abort,
    output logic [BITS-1:0] Q,
    output logic            busy,
    output logic            done
);

    localparam logic [BITS-1:0] C_ONE = {{(BITS-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic [BITS-1:0] start_q, start_d;
    logic [BITS-1:0] end_q, end_d;

    logic            cnt_load;
    logic [BITS-1:0] cnt_load_val;
    logic            cnt_en;
    logic [BITS-1:0] cnt_next;

    // Terminal detection looks at the value the counter is about to take,
    // so DONE is entered on the same edge that Q reaches the end value.
    assign cnt_next = (dir_q == DIR_UP) ? (Q + C_ONE) : (Q - C_ONE);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        start_d      = start_q;
        end_d        = end_q;
        cnt_load     = 1'b0;
        cnt_load_val = start_q;
        cnt_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    dir_d        = dir;
                    start_d      = start_val;
                    end_d        = end_val;
                    cnt_load     = 1'b1;
                    cnt_load_val = start_val;
                    state_d      = (start_val == end_val) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_next == end_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (!AUTO_RELOAD || abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = (start_q == end_q) ? S_DONE : S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    syn_up_down_counter_bv #(
        .BITS (BITS)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .dir      (dir_q),
        .Q        (Q)
    );

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule : syn_counter_ctrl
`default_nettype wire

// File: tb/tb_syn_counter_ctrl.sv
`default_nettype none
// ============================================================================
// tb_syn_counter_ctrl : directed vector bench for syn_counter_ctrl
// Revision            : 1.0
// ============================================================================
module tb_syn_counter_ctrl;

    localparam int BITS = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            st0, dir0, pa0, ab0;
    logic [BITS-1:0] sv0, ev0, q0;
    logic            busy0, done0;
    logic            st1, dir1, pa1, ab1;
    logic [BITS-1:0] sv1, ev1, q1;
    logic            busy1, done1;

    syn_counter_ctrl #(.BITS(BITS), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(st0), .dir(dir0),
        .start_val(sv0), .end_val(ev0), .pause(pa0), .abort(ab0),
        .Q(q0), .busy(busy0), .done(done0)
    );

    syn_counter_ctrl #(.BITS(BITS), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(st1), .dir(dir1),
        .start_val(sv1), .end_val(ev1), .pause(pa1), .abort(ab1),
        .Q(q1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic            st;
        logic            dir;
        logic [BITS-1:0] sv;
        logic [BITS-1:0] ev;
        logic            pa;
        logic            ab;
        logic [BITS-1:0] q;
        logic            busy;
        logic            done;
    } vec_t;

    vec_t tbl[80];
    int   n_vec   = 0;
    int   n_apply = 0;
    int   n_fail  = 0;

    task automatic add(input logic st, input logic dir, input int sv, input int ev,
                       input logic pa, input logic ab, input int q, input logic b, input logic d);
        tbl[n_vec].st   = st;
        tbl[n_vec].dir  = dir;
        tbl[n_vec].sv   = sv[BITS-1:0];
        tbl[n_vec].ev   = ev[BITS-1:0];
        tbl[n_vec].pa   = pa;
        tbl[n_vec].ab   = ab;
        tbl[n_vec].q    = q[BITS-1:0];
        tbl[n_vec].busy = b;
        tbl[n_vec].done = d;
        n_vec++;
    endtask

    task automatic idle(input int q, input logic b, input logic d);
        add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, q, b, d);
    endtask

    task automatic chk(input string nm, input logic [BITS-1:0] aq, input logic ab_, input logic ad,
                       input logic [BITS-1:0] eq, input logic eb, input logic ed);
        n_apply++;
        if (aq !== eq || ab_ !== eb || ad !== ed) begin
            n_fail++;
            $display("FAIL %s: got Q=%0d busy=%b done=%b, expected Q=%0d busy=%b done=%b",
                     nm, aq, ab_, ad, eq, eb, ed);
        end
    endtask

    task automatic drive0(input logic st, input logic dir, input logic [BITS-1:0] sv,
                          input logic [BITS-1:0] ev, input logic pa, input logic ab);
        st0 = st; dir0 = dir; sv0 = sv; ev0 = ev; pa0 = pa; ab0 = ab;
    endtask

    task automatic step1(input logic st, input logic pa, input logic ab,
                         input int eq, input logic eb, input logic ed, input string nm);
        st1 = st; pa1 = pa; ab1 = ab;
        @(posedge clk); #1;
        chk(nm, q1, busy1, done1, eq[BITS-1:0], eb, ed);
    endtask

    initial begin
        reset_n = 1'b0;
        drive0(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        st1 = 1'b0; dir1 = 1'b1; sv1 = 5'd1; ev1 = 5'd3; pa1 = 1'b0; ab1 = 1'b0;

        // up 3 -> 7
        add(1, 1, 3, 7, 0, 0, 3, 1, 0);
        idle(4, 1, 0); idle(5, 1, 0); idle(6, 1, 0);
        idle(7, 1, 1); idle(7, 0, 0); idle(7, 0, 0);
        // down 2 -> 30 across the wrap
        add(1, 0, 2, 30, 0, 0, 2, 1, 0);
        idle(1, 1, 0); idle(0, 1, 0); idle(31, 1, 0);
        idle(30, 1, 1); idle(30, 0, 0);
        // up 0 -> 5, pause 3 cycles at Q=2, start mid-run ignored
        add(1, 1, 0, 5, 0, 0, 0, 1, 0);
        idle(1, 1, 0); idle(2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 2, 1, 0);
        idle(2, 1, 0);
        add(1, 0, 17, 9, 0, 0, 3, 1, 0);
        idle(4, 1, 0); idle(5, 1, 1); idle(5, 0, 0);
        // up 0 -> 20, abort at Q=4; start+abort in IDLE ignored
        add(1, 1, 0, 20, 0, 0, 0, 1, 0);
        idle(1, 1, 0); idle(2, 1, 0); idle(3, 1, 0); idle(4, 1, 0);
        add(0, 0, 0, 0, 0, 1, 4, 0, 0);
        idle(4, 0, 0);
        add(1, 1, 9, 12, 0, 1, 4, 0, 0);
        idle(4, 0, 0);
        // start == end
        add(1, 1, 9, 9, 0, 0, 9, 1, 1);
        idle(9, 0, 0);
        // up wrap 30 -> 1, pause then abort from HOLD
        add(1, 1, 30, 1, 0, 0, 30, 1, 0);
        idle(31, 1, 0); idle(0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        // abort beats pause in RUN
        add(1, 1, 5, 6, 0, 0, 5, 1, 0);
        add(0, 0, 0, 0, 1, 1, 5, 0, 0);
        // start during DONE ignored, earliest restart accepted
        add(1, 1, 1, 2, 0, 0, 1, 1, 0);
        idle(2, 1, 1);
        add(1, 1, 7, 8, 0, 0, 2, 0, 0);
        add(1, 0, 4, 4, 0, 0, 4, 1, 1);
        idle(4, 0, 0);

        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1 chk("reset", q0, busy0, done0, '0, 1'b0, 1'b0);
        chk("reset_ar", q1, busy1, done1, '0, 1'b0, 1'b0);

        for (int i = 0; i < n_vec; i++) begin
            drive0(tbl[i].st, tbl[i].dir, tbl[i].sv, tbl[i].ev, tbl[i].pa, tbl[i].ab);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), q0, busy0, done0, tbl[i].q, tbl[i].busy, tbl[i].done);
        end

        // asynchronous reset in the middle of a run
        drive0(1'b1, 1'b1, 5'd0, 5'd20, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive0(1'b0, 1'b1, 5'd0, 5'd20, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("pre_async_rst", q0, busy0, done0, 5'd2, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk("async_rst", q0, busy0, done0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("async_rst_hold", q0, busy0, done0, '0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;

        // auto-reload 1 -> 3, pause in DONE ignored, abort returns to IDLE
        step1(1, 0, 0, 1, 1, 0, "ar_start");
        step1(0, 0, 0, 2, 1, 0, "ar_2a");
        step1(0, 0, 0, 3, 1, 1, "ar_3a");
        step1(0, 0, 0, 1, 1, 0, "ar_1b");
        step1(0, 0, 0, 2, 1, 0, "ar_2b");
        step1(0, 0, 0, 3, 1, 1, "ar_3b");
        step1(0, 1, 0, 1, 1, 0, "ar_pause_done");
        step1(0, 0, 0, 2, 1, 0, "ar_2c");
        step1(0, 0, 1, 2, 0, 0, "ar_abort");
        step1(0, 0, 0, 2, 0, 0, "ar_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_apply, n_fail);
        $finish;
    end

endmodule : tb_syn_counter_ctrl
`default_nettype wire
